// File: rtl/t_counter_pkg.sv
// t_counter_pkg: mode encodings shared by the toggle counter and its bench
package t_counter_pkg;
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    LOAD = 2'b11
  } mode_e;
endpackage

// File: rtl/t_counter_t_ff_cell.sv
// t_ff_cell: single toggle flop with synchronous active-low clear
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  // invert on t, clear when rst is low at the edge
  always_ff @(posedge clk) q <= !rst ? 1'b0 : q ^ t;
endmodule

// File: rtl/t_counter.sv
// t_counter: up/down/load counter built from per-bit toggle cells
module t_counter
  import t_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  mode_e m;
  logic [WIDTH-1:0] up_t, dn_t, tog;
  assign m = mode_e'(mode);
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
        assign up_t[i] = 1'b1;
        assign dn_t[i] = 1'b1;
      end else begin : g_upper
        assign up_t[i] = &q[i-1:0];
        assign dn_t[i] = ~|q[i-1:0];
      end
      t_ff_cell u_cell (.clk(clk), .rst(rst), .t(tog[i]), .q(q[i]));
    end
  endgenerate
  // terminal count: the next enabled step would cross a limit
  always_comb tc = en && ((m == UP && &q) || (m == DOWN && ~|q));
  // toggle vector: nothing to flip when idle or pinned at a saturated limit
  always_comb tog = (!en || m == HOLD || (SATURATE && tc)) ? '0 :
                    m == LOAD ? q ^ load_val :
                    m == UP   ? up_t : dn_t;
  // limit event is reported one cycle after tc was seen
  always_ff @(posedge clk) ovf <= !rst ? 1'b0 : tc;
endmodule

// File: tb/tb_t_counter.sv
// tb_t_counter: scoreboard bench for t_counter in wrap and saturate builds
module tb_t_counter;
  import t_counter_pkg::*;
  typedef struct {logic r; logic e; logic [1:0] m; logic [7:0] l;} stim_t;
  typedef struct {logic [7:0] q; logic ovf; logic tc;} exp_t;
  logic clk = 1'b0;
  logic rst_v [3];
  logic en_v [3];
  logic [1:0] mode_v [3];
  logic [7:0] ld_v [3];
  logic [3:0] q0, q1;
  logic [7:0] q2;
  logic tc_v [3];
  logic ovf_v [3];
  exp_t sb [$];
  logic [7:0] mq;
  int n_cmp = 0;
  int n_err = 0;
  t_counter #(.WIDTH(4), .SATURATE(1'b0)) d0 (.clk(clk), .rst(rst_v[0]), .en(en_v[0]),
    .mode(mode_v[0]), .load_val(ld_v[0][3:0]), .q(q0), .tc(tc_v[0]), .ovf(ovf_v[0]));
  t_counter #(.WIDTH(4), .SATURATE(1'b1)) d1 (.clk(clk), .rst(rst_v[1]), .en(en_v[1]),
    .mode(mode_v[1]), .load_val(ld_v[1][3:0]), .q(q1), .tc(tc_v[1]), .ovf(ovf_v[1]));
  t_counter #(.WIDTH(8), .SATURATE(1'b0)) d2 (.clk(clk), .rst(rst_v[2]), .en(en_v[2]),
    .mode(mode_v[2]), .load_val(ld_v[2]), .q(q2), .tc(tc_v[2]), .ovf(ovf_v[2]));
  always #5 clk = ~clk;
  function automatic stim_t st(logic r, logic e, logic [1:0] m, logic [7:0] l);
    stim_t s;
    s.r = r; s.e = e; s.m = m; s.l = l;
    return s;
  endfunction
  function automatic logic [7:0] obs_q(int k);
    return k == 0 ? {4'b0, q0} : k == 1 ? {4'b0, q1} : q2;
  endfunction
  task automatic drive(input int k, input stim_t s);
    logic [7:0] mk;
    logic sat, tcv;
    exp_t x;
    mk = k == 2 ? 8'hFF : 8'h0F;
    sat = k == 1;
    rst_v[k] = s.r; en_v[k] = s.e; mode_v[k] = s.m; ld_v[k] = s.l;
    tcv = s.e && ((s.m == UP && mq == mk) || (s.m == DOWN && mq == 8'h00));
    x.tc = tcv;
    x.ovf = s.r && tcv;
    if (!s.r) x.q = 8'h00;
    else if (!s.e || s.m == HOLD) x.q = mq;
    else if (s.m == LOAD) x.q = s.l & mk;
    else if (sat && tcv) x.q = mq;
    else if (s.m == UP) x.q = (mq + 8'd1) & mk;
    else x.q = (mq - 8'd1) & mk;
    mq = x.q;
    sb.push_back(x);
  endtask
  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(0, st(1'b0, 1'b0, HOLD, 8'h0)); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[0] !== x.tc) begin n_err++; $display("FAIL reset_tc got=%b want=%b", tc_v[0], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(0) !== x.q) begin n_err++; $display("FAIL reset_q got=%h want=%h", obs_q(0), x.q); end
      n_cmp++; if (ovf_v[0] !== x.ovf) begin n_err++; $display("FAIL reset_ovf got=%b want=%b", ovf_v[0], x.ovf); end
    end
  endtask
  task automatic test_up_wrap();
    stim_t s [$];
    exp_t x;
    s = '{st(1'b0, 1'b0, HOLD, 8'h0), st(1'b0, 1'b0, HOLD, 8'h0)};
    for (int i = 0; i < 20; i++) s.push_back(st(1'b1, 1'b1, UP, 8'h0));
    foreach (s[i]) begin
      @(negedge clk); drive(0, s[i]); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[0] !== x.tc) begin n_err++; $display("FAIL up_wrap_tc step=%0d got=%b want=%b", i, tc_v[0], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(0) !== x.q) begin n_err++; $display("FAIL up_wrap_q step=%0d got=%h want=%h", i, obs_q(0), x.q); end
      n_cmp++; if (ovf_v[0] !== x.ovf) begin n_err++; $display("FAIL up_wrap_ovf step=%0d got=%b want=%b", i, ovf_v[0], x.ovf); end
    end
  endtask
  task automatic test_load_down();
    stim_t s [$];
    exp_t x;
    s = '{st(1'b0, 1'b0, HOLD, 8'h0), st(1'b1, 1'b1, LOAD, 8'h2), st(1'b1, 1'b1, DOWN, 8'h0),
          st(1'b1, 1'b1, DOWN, 8'h0), st(1'b1, 1'b1, DOWN, 8'h0), st(1'b1, 1'b1, DOWN, 8'h0),
          st(1'b1, 1'b1, HOLD, 8'h0)};
    foreach (s[i]) begin
      @(negedge clk); drive(0, s[i]); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[0] !== x.tc) begin n_err++; $display("FAIL load_down_tc step=%0d got=%b want=%b", i, tc_v[0], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(0) !== x.q) begin n_err++; $display("FAIL load_down_q step=%0d got=%h want=%h", i, obs_q(0), x.q); end
      n_cmp++; if (ovf_v[0] !== x.ovf) begin n_err++; $display("FAIL load_down_ovf step=%0d got=%b want=%b", i, ovf_v[0], x.ovf); end
    end
  endtask
  task automatic test_saturate();
    stim_t s [$];
    exp_t x;
    s = '{st(1'b0, 1'b0, HOLD, 8'h0), st(1'b1, 1'b1, LOAD, 8'hE), st(1'b1, 1'b1, UP, 8'h0),
          st(1'b1, 1'b1, UP, 8'h0), st(1'b1, 1'b1, UP, 8'h0), st(1'b1, 1'b1, UP, 8'h0),
          st(1'b0, 1'b1, UP, 8'h0), st(1'b1, 1'b1, DOWN, 8'h0), st(1'b1, 1'b1, DOWN, 8'h0),
          st(1'b1, 1'b1, HOLD, 8'h0)};
    foreach (s[i]) begin
      @(negedge clk); drive(1, s[i]); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[1] !== x.tc) begin n_err++; $display("FAIL saturate_tc step=%0d got=%b want=%b", i, tc_v[1], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(1) !== x.q) begin n_err++; $display("FAIL saturate_q step=%0d got=%h want=%h", i, obs_q(1), x.q); end
      n_cmp++; if (ovf_v[1] !== x.ovf) begin n_err++; $display("FAIL saturate_ovf step=%0d got=%b want=%b", i, ovf_v[1], x.ovf); end
    end
  endtask
  task automatic test_enable_hold();
    stim_t s [$];
    exp_t x;
    s = '{st(1'b0, 1'b0, HOLD, 8'h0), st(1'b1, 1'b1, LOAD, 8'h36), st(1'b1, 1'b1, UP, 8'h0),
          st(1'b1, 1'b0, UP, 8'h0), st(1'b1, 1'b0, DOWN, 8'h0), st(1'b1, 1'b0, LOAD, 8'h55),
          st(1'b1, 1'b1, HOLD, 8'h55), st(1'b1, 1'b1, UP, 8'h0)};
    foreach (s[i]) begin
      @(negedge clk); drive(2, s[i]); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[2] !== x.tc) begin n_err++; $display("FAIL enable_hold_tc step=%0d got=%b want=%b", i, tc_v[2], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(2) !== x.q) begin n_err++; $display("FAIL enable_hold_q step=%0d got=%h want=%h", i, obs_q(2), x.q); end
      n_cmp++; if (ovf_v[2] !== x.ovf) begin n_err++; $display("FAIL enable_hold_ovf step=%0d got=%b want=%b", i, ovf_v[2], x.ovf); end
    end
  endtask
  task automatic test_reset_mid();
    stim_t s [$];
    exp_t x;
    s = '{st(1'b0, 1'b0, HOLD, 8'h0), st(1'b1, 1'b1, LOAD, 8'h7F), st(1'b1, 1'b1, UP, 8'h0),
          st(1'b0, 1'b1, LOAD, 8'hAA), st(1'b1, 1'b1, UP, 8'h0), st(1'b1, 1'b1, UP, 8'h0),
          st(1'b1, 1'b1, UP, 8'h0)};
    foreach (s[i]) begin
      @(negedge clk); drive(2, s[i]); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[2] !== x.tc) begin n_err++; $display("FAIL reset_mid_tc step=%0d got=%b want=%b", i, tc_v[2], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(2) !== x.q) begin n_err++; $display("FAIL reset_mid_q step=%0d got=%h want=%h", i, obs_q(2), x.q); end
      n_cmp++; if (ovf_v[2] !== x.ovf) begin n_err++; $display("FAIL reset_mid_ovf step=%0d got=%b want=%b", i, ovf_v[2], x.ovf); end
    end
  endtask
  task automatic test_back_to_back();
    stim_t s [$];
    exp_t x;
    s = '{st(1'b0, 1'b0, HOLD, 8'h0), st(1'b1, 1'b1, LOAD, 8'hFF), st(1'b1, 1'b1, UP, 8'h0),
          st(1'b1, 1'b1, DOWN, 8'h0), st(1'b1, 1'b1, LOAD, 8'h10), st(1'b1, 1'b1, UP, 8'h0),
          st(1'b1, 1'b1, DOWN, 8'h0), st(1'b1, 1'b1, UP, 8'h0), st(1'b1, 1'b1, DOWN, 8'h0)};
    foreach (s[i]) begin
      @(negedge clk); drive(2, s[i]); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[2] !== x.tc) begin n_err++; $display("FAIL b2b_tc step=%0d got=%b want=%b", i, tc_v[2], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(2) !== x.q) begin n_err++; $display("FAIL b2b_q step=%0d got=%h want=%h", i, obs_q(2), x.q); end
      n_cmp++; if (ovf_v[2] !== x.ovf) begin n_err++; $display("FAIL b2b_ovf step=%0d got=%b want=%b", i, ovf_v[2], x.ovf); end
    end
  endtask
  task automatic test_random(input int k);
    stim_t s [$];
    exp_t x;
    s = '{st(1'b0, 1'b0, HOLD, 8'h0)};
    for (int i = 0; i < 60; i++)
      s.push_back(st($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                     2'($urandom_range(0, 3)), 8'($urandom)));
    foreach (s[i]) begin
      @(negedge clk); drive(k, s[i]); #1;
      x = sb.pop_front();
      n_cmp++; if (tc_v[k] !== x.tc) begin n_err++; $display("FAIL random_tc dut=%0d step=%0d got=%b want=%b", k, i, tc_v[k], x.tc); end
      @(posedge clk); #1;
      n_cmp++; if (obs_q(k) !== x.q) begin n_err++; $display("FAIL random_q dut=%0d step=%0d got=%h want=%h", k, i, obs_q(k), x.q); end
      n_cmp++; if (ovf_v[k] !== x.ovf) begin n_err++; $display("FAIL random_ovf dut=%0d step=%0d got=%b want=%b", k, i, ovf_v[k], x.ovf); end
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b0; en_v[k] = 1'b0; mode_v[k] = HOLD; ld_v[k] = 8'h00;
    end
    mq = 8'h00;
    test_reset();
    test_up_wrap();
    test_load_down();
    test_saturate();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    test_random(1);
    test_random(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
